// File: rtl/xy_route_input_port.sv
// Router input port: small stream FIFO plus XY route decode, steering each
// packet (header + payload beats) to exactly one output arbiter stream.
module xy_route_input_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int DEST_WIDTH     = 4,
  parameter int USER_WIDTH     = 1,
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int ROUTING_HEADER = 1,
  localparam int CHW = $clog2(CHANNEL_NUMBER)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_in_tvalid,
  output logic                                       o_in_tready,
  input  logic [DATA_WIDTH-1:0]                      i_in_tdata,
  input  logic [ID_WIDTH-1:0]                        i_in_tid,
  input  logic [DEST_WIDTH-1:0]                      i_in_tdest,
  input  logic [USER_WIDTH-1:0]                      i_in_tuser,
  output logic [CHANNEL_NUMBER-1:0]                  o_out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]                  i_out_tready,
  output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]  o_out_tdata,
  output logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0]    o_out_tid,
  output logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0]  o_out_tdest,
  output logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0]  o_out_tuser,
  output logic [CHW-1:0]                             o_route_port,
  output logic                                       o_busy,
  output logic                                       o_drop_pulse
);

  localparam int XW = $clog2(MAX_ROUTERS_X);
  localparam int YW = $clog2(MAX_ROUTERS_Y);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = ID_WIDTH + DEST_WIDTH + USER_WIDTH + DATA_WIDTH;

  localparam logic [CHW-1:0] P_LOCAL = CHW'(0);
  localparam logic [CHW-1:0] P_NORTH = CHW'(1);
  localparam logic [CHW-1:0] P_SOUTH = CHW'(2);
  localparam logic [CHW-1:0] P_EAST  = CHW'(3);
  localparam logic [CHW-1:0] P_WEST  = CHW'(4);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FWD = 1'b1} state_t;

  logic [BW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  state_t                r_state, w_next_state;
  logic [7:0]            r_beats_left;
  logic [CHW-1:0]        r_route_port;

  logic                  w_push, w_pop, w_latch, w_drop, w_not_empty, w_is_hdr;
  logic [CHANNEL_NUMBER-1:0] w_valid;
  logic [ID_WIDTH-1:0]   w_h_tid;
  logic [DEST_WIDTH-1:0] w_h_tdest;
  logic [USER_WIDTH-1:0] w_h_tuser;
  logic [DATA_WIDTH-1:0] w_h_tdata;
  logic [XW-1:0]         w_tx;
  logic [YW-1:0]         w_ty;
  logic [7:0]            w_beats;
  logic [CHW-1:0]        w_route;

  assign {w_h_tid, w_h_tdest, w_h_tuser, w_h_tdata} = r_mem[r_rd_ptr];
  assign w_not_empty = (r_count != {CW{1'b0}});
  assign o_in_tready = (r_count != CW'(FIFO_DEPTH));
  assign w_push      = i_in_tvalid & o_in_tready;
  assign w_is_hdr    = (w_h_tid == ID_WIDTH'(ROUTING_HEADER));
  assign w_ty        = w_h_tdata[YW-1:0];
  assign w_tx        = w_h_tdata[XW+YW-1:YW];
  assign w_beats     = w_h_tdata[(XW+YW)*2 +: 8];

  // Dimension-ordered route: resolve X first, then Y, else deliver locally.
  always_comb begin
    w_route = P_LOCAL;
    if (w_tx > XW'(ROUTER_X))      w_route = P_EAST;
    else if (w_tx < XW'(ROUTER_X)) w_route = P_WEST;
    else if (w_ty > YW'(ROUTER_Y)) w_route = P_SOUTH;
    else if (w_ty < YW'(ROUTER_Y)) w_route = P_NORTH;
    else                           w_route = P_LOCAL;
  end

  // Storage is data-only, so it is not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_in_tid, i_in_tdest, i_in_tuser, i_in_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beats_left <= 8'd0;
      r_route_port <= {CHW{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_route_port <= w_route;
        r_beats_left <= w_beats;
      end else if (w_pop && r_state == S_FWD) begin
        r_beats_left <= r_beats_left - 8'd1;
      end
    end
  end

  // Valid is a function of state and FIFO head only, never of the sink's ready.
  always_comb begin
    w_next_state = r_state;
    w_valid      = {CHANNEL_NUMBER{1'b0}};
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty && w_is_hdr) begin
          w_valid[w_route] = 1'b1;
          if (i_out_tready[w_route]) begin
            w_pop        = 1'b1;
            w_latch      = 1'b1;
            w_next_state = (w_beats != 8'd0) ? S_FWD : S_IDLE;
          end else begin
            w_next_state = S_IDLE;
          end
        end else if (w_not_empty) begin
          w_pop  = 1'b1;
          w_drop = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FWD: begin
        w_valid[r_route_port] = w_not_empty;
        if (w_not_empty && i_out_tready[r_route_port]) begin
          w_pop        = 1'b1;
          w_next_state = (r_beats_left == 8'd1) ? S_IDLE : S_FWD;
        end else begin
          w_next_state = S_FWD;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_out_tvalid = w_valid;
  assign o_out_tdata  = {CHANNEL_NUMBER{w_h_tdata}};
  assign o_out_tid    = {CHANNEL_NUMBER{w_h_tid}};
  assign o_out_tdest  = {CHANNEL_NUMBER{w_h_tdest}};
  assign o_out_tuser  = {CHANNEL_NUMBER{w_h_tuser}};
  assign o_route_port = r_route_port;
  assign o_busy       = (r_state == S_FWD);
  assign o_drop_pulse = w_drop;

endmodule
